// File: rtl/fp_mul_arbiter_pkg.sv
// Shared widths, FSM encodings and operand struct for the FP multiplier arbiter.
package fp_mul_arbiter_pkg;
    localparam int FP_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_op_t;
endpackage

// File: rtl/Floating_Point_Multiplication.sv
// Combinational IEEE-754 single multiplier: truncating, zero/denormal inputs flush to
// signed zero, exponent overflow saturates to signed infinity and raises overflow.
module Floating_Point_Multiplication (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] ans,
    output logic        overflow
);
    logic        sign;
    logic [47:0] prod;
    logic [9:0]  exp_sum;
    logic [22:0] frac;

    always_comb begin
        sign     = a[31] ^ b[31];
        prod     = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        // biased sum still carries one extra bias; compared against 127+255 and 127
        exp_sum  = {2'b0, a[30:23]} + {2'b0, b[30:23]} + {9'b0, prod[47]};
        frac     = prod[47] ? prod[46:24] : prod[45:23];
        ans      = {sign, 31'b0};
        overflow = 1'b0;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            ans = {sign, 31'b0};
        end else if (exp_sum >= 10'd382) begin
            ans      = {sign, 8'hFF, 23'b0};
            overflow = 1'b1;
        end else if (exp_sum > 10'd127) begin
            ans = {sign, 8'(exp_sum - 10'd127), frac};
        end
    end
endmodule

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end
endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin time-sharing of one combinational FP multiplier between NUM_REQ clients,
// with registered operands and result around the multiplier.
module fp_mul_arbiter
    import fp_mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [FP_W-1:0]         resp_ans,
    output logic                    resp_overflow,
    output logic                    busy
);
    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    fp_op_t             op_q, op_d;
    logic [FP_W-1:0]    ans_q, ans_d;
    logic               ovf_q, ovf_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic [FP_W-1:0]    mul_ans;
    logic               mul_ovf;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    Floating_Point_Multiplication u_mul (
        .a        (op_q.a),
        .b        (op_q.b),
        .ans      (mul_ans),
        .overflow (mul_ovf)
    );

    assign req_ready     = (state_q == ST_IDLE) ? arb_gnt : '0;
    assign resp_valid    = (state_q == ST_RESP) ? (NUM_REQ'(1) << gnt_id_q) : '0;
    assign resp_ans      = ans_q;
    assign resp_overflow = ovf_q;
    assign busy          = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        op_d     = op_q;
        ans_d    = ans_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: if (|(req_valid & arb_gnt)) begin
                op_d.a   = req_a[arb_idx*FP_W +: FP_W];
                op_d.b   = req_b[arb_idx*FP_W +: FP_W];
                gnt_id_d = arb_idx;
                // the winner drops to lowest priority next round
                rr_ptr_d = (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                ans_d   = mul_ans;
                ovf_d   = mul_ovf;
                state_d = ST_RESP;
            end
            ST_RESP: if (resp_ready[gnt_id_q]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
            op_q     <= '0;
            ans_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
            op_q     <= op_d;
            ans_q    <= ans_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized + directed bench for fp_mul_arbiter against a transaction-level model.
module tb_fp_mul_arbiter;
    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_ready, resp_valid, resp_ready = '0;
    logic [N*32-1:0] req_a = '0, req_b = '0;
    logic [31:0]     resp_ans;
    logic            resp_overflow, busy;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    fp_mul_arbiter #(.NUM_REQ(N), .ID_W(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_ans(resp_ans), .resp_overflow(resp_overflow), .busy(busy)
    );

    // model: pending ops per client, phase since accept, last served client
    logic [N-1:0] pend = '0;
    logic [31:0]  pa [N];
    logic [31:0]  pb [N];
    int           ph = 0, ptr = 0, gnt = 0, n_resp = 0;
    int           rr_pct = 100, new_pct = 0;
    logic [31:0]  m_ans = '0, last_ans = '0, seen_ans = '0;
    logic         m_ovf = 1'b0, last_ovf = 1'b0, seen_ovf = 1'b0;
    logic [N-1:0] seen_vld = '0;
    logic [N-1:0] dut_gnt [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void mul_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] ans, output logic ovf);
        int              e;
        longint unsigned m;
        logic            s;
        s   = a[31] ^ b[31];
        ovf = 1'b0;
        ans = {s, 31'b0};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return;
        m = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        while (m >= (64'd1 << 47)) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) begin
            ans = {s, 8'hFF, 23'b0};
            ovf = 1'b1;
        end else if (e >= 1) begin
            ans = {s, e[7:0], m[45:23]};
        end
    endfunction

    function automatic int pick();
        for (int j = 0; j < N; j++)
            if (pend[(ptr + j) % N]) return (ptr + j) % N;
        return -1;
    endfunction

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = pa[i];
            req_b[i*32 +: 32] = pb[i];
        end
    endtask

    task automatic check();
        logic [N-1:0] exp_rdy;
        int           k;
        exp_rdy = '0;
        k = pick();
        if (ph == 0 && k >= 0) exp_rdy[k] = 1'b1;
        chk("busy", 64'(busy), 64'(ph != 0));
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("resp_valid", 64'(resp_valid), (ph == 2) ? 64'(1) << gnt : 64'd0);
        chk("resp_ans", 64'(resp_ans), 64'(last_ans));
        chk("resp_ovf", 64'(resp_overflow), 64'(last_ovf));
        if (ph == 0 && |req_ready) dut_gnt.push_back(req_ready);
        if (ph == 2) begin
            seen_ans = resp_ans;
            seen_ovf = resp_overflow;
            seen_vld = resp_valid;
        end
    endtask

    task automatic update();
        int k;
        case (ph)
            0: begin
                k = pick();
                if (k >= 0) begin
                    gnt = k;
                    ptr = (k + 1) % N;
                    mul_model(pa[k], pb[k], m_ans, m_ovf);
                    pend[k] = 1'b0;
                    ph = 1;
                end
            end
            1: begin
                ph = 2;
                last_ans = m_ans;
                last_ovf = m_ovf;
            end
            default: if (resp_ready[gnt]) begin
                ph = 0;
                n_resp++;
            end
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(99) < new_pct) begin
                pend[i] = 1'b1;
                pa[i] = $urandom();
                pb[i] = $urandom();
            end
        for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(99) < rr_pct);
        drive();
        #1;
        check();
        update();
    endtask

    task automatic wait_resp();
        int n0;
        n0 = n_resp;
        for (int c = 0; c < 40 && n_resp == n0; c++) step();
        if (n_resp == n0) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic post(input int k, input logic [31:0] a, input logic [31:0] b);
        pend[k] = 1'b1;
        pa[k] = a;
        pb[k] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        pend = '0;
        drive();
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_ans", 64'(resp_ans), 64'd0);
        chk("rst_ovf", 64'(resp_overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        ph = 0; ptr = 0; last_ans = '0; last_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        #2;
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // single request, client 0: 2.5 * 2.5
        post(0, 32'h40200000, 32'h40200000);
        wait_resp();
        chk("t2_ans", 64'(seen_ans), 64'h40C80000);
        chk("t2_ovf", 64'(seen_ovf), 64'd0);
        chk("t2_vld", 64'(seen_vld), 64'b01);

        // sign: client 1, -2.5 * 2.0
        post(1, 32'hC0200000, 32'h40000000);
        wait_resp();
        chk("t3_ans", 64'(seen_ans), 64'hC0A00000);
        chk("t3_vld", 64'(seen_vld), 64'b10);

        // async reset while a response is waiting
        rr_pct = 0;
        post(0, 32'h3FC00000, 32'h40400000);
        for (int c = 0; c < 5; c++) step();
        chk("t1_in_resp", 64'(resp_valid), 64'b01);
        do_reset();
        for (int c = 0; c < 4; c++) step();

        // contention from reset: both clients always valid
        rr_pct = 100;
        new_pct = 100;
        dut_gnt.delete();
        for (int o = 0; o < 4; o++) wait_resp();
        chk("t4_ngnt", 64'(dut_gnt.size()), 64'd4);
        for (int o = 0; o < 4 && o < dut_gnt.size(); o++)
            chk("t4_order", 64'(dut_gnt[o]), (o % 2 == 0) ? 64'b01 : 64'b10);

        // backpressure with a competing request pending
        new_pct = 0;
        pend = '0;
        repeat (4) step();
        rr_pct = 0;
        post(0, 32'h40200000, 32'h40400000);
        for (int c = 0; c < 3; c++) step();
        post(1, 32'h40000000, 32'h40000000);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t5_hold_ready", 64'(req_ready), 64'd0);
            chk("t5_hold_busy", 64'(busy), 64'd1);
        end
        rr_pct = 100;
        step();
        step();
        chk("t5_idle", 64'(busy), 64'd0);
        wait_resp();

        // overflow
        post(0, 32'h7F000000, 32'h7F000000);
        wait_resp();
        chk("t6_ovf", 64'(seen_ovf), 64'd1);
        chk("t6_ans", 64'(seen_ans), 64'h7F800000);

        // randomized traffic and backpressure
        for (int r = 0; r < 4; r++) begin
            new_pct = 20 + 25 * r;
            rr_pct = 30 + 20 * r;
            for (int c = 0; c < 250; c++) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
